// File: rtl/bram_stream_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bram_stream_fifo_pkg
// Shared constants and helpers for the BRAM-backed stream FIFO.
//   - Default data width / depth / address width / almost-full threshold.
//   - Output buffer depth and its count width.
//   - obuf_demand(): words already committed to the output buffer once the
//     current cycle's pop has been taken into account.
// -----------------------------------------------------------------------------
package bram_stream_fifo_pkg;

    localparam int WIDTH_DEF        = 72;
    localparam int DEPTH_DEF        = 512;
    localparam int LOG_DEPTH_DEF    = 9;
    localparam int AFULL_THRESH_DEF = 480;

    // Two entries hide the one-cycle BRAM read latency at full rate.
    localparam int OBUF_DEPTH = 2;
    localparam int OBUF_CNT_W = 2;

    typedef enum logic [1:0] {
        OBUF_EMPTY = 2'd0,
        OBUF_ONE   = 2'd1,
        OBUF_FULL  = 2'd2
    } obuf_fill_e;

    // Occupied output-buffer slots plus the read still travelling out of the
    // BRAM, minus the word leaving this cycle. A new read may only be issued
    // when this is below OBUF_DEPTH, so every returning word has a slot.
    function automatic logic [2:0] obuf_demand(
        input logic [OBUF_CNT_W-1:0] cnt,
        input logic                  inflight,
        input logic                  pop
    );
        obuf_demand = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage : bram_stream_fifo_pkg

// File: rtl/bram_fifo_obuf.sv
// -----------------------------------------------------------------------------
// bram_fifo_obuf
// Two-entry register FIFO that sits behind the BRAM read port and presents the
// egress stream head. Push and pop may happen in the same cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data (ignored when full and not popping)
//   push_data   word returning from the BRAM
//   pop         remove head (ignored when empty)
//   head_data   current head word (registered)
//   valid       head is valid (registered)
//   cnt         number of stored words, 0..2 (registered)
// -----------------------------------------------------------------------------
module bram_fifo_obuf
    import bram_stream_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic                  valid,
    output logic [OBUF_CNT_W-1:0] cnt
);

    logic [WIDTH-1:0]      entry0_r, entry1_r;
    logic [WIDTH-1:0]      entry0_next_s, entry1_next_s;
    logic [OBUF_CNT_W-1:0] cnt_r, cnt_next_s;
    logic                  valid_r;
    logic                  pop_s, push_s;

    // Qualify requests so a bad caller can never under- or overflow the buffer.
    always_comb begin
        pop_s  = pop & (cnt_r != OBUF_EMPTY);
        push_s = push & ((cnt_r != OBUF_FULL) | pop_s);
    end

    // Next-state for the two entries; entry0 is always the head.
    always_comb begin
        entry0_next_s = entry0_r;
        entry1_next_s = entry1_r;
        cnt_next_s    = cnt_r;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_r == OBUF_EMPTY) begin
                    entry0_next_s = push_data;
                end else begin
                    entry1_next_s = push_data;
                end
                cnt_next_s = cnt_r + 2'd1;
            end
            2'b01: begin
                entry0_next_s = entry1_r;
                cnt_next_s    = cnt_r - 2'd1;
            end
            2'b11: begin
                if (cnt_r == OBUF_ONE) begin
                    entry0_next_s = push_data;
                end else begin
                    entry0_next_s = entry1_r;
                    entry1_next_s = push_data;
                end
            end
            default: begin
                cnt_next_s = cnt_r;
            end
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_r <= '0;
            entry1_r <= '0;
            cnt_r    <= OBUF_EMPTY;
            valid_r  <= 1'b0;
        end else begin
            entry0_r <= entry0_next_s;
            entry1_r <= entry1_next_s;
            cnt_r    <= cnt_next_s;
            valid_r  <= (cnt_next_s != OBUF_EMPTY);
        end
    end

    assign head_data = entry0_r;
    assign valid     = valid_r;
    assign cnt       = cnt_r;

endmodule : bram_fifo_obuf

// File: rtl/bram_stream_fifo.sv
// -----------------------------------------------------------------------------
// bram_stream_fifo
// Valid/ready stream FIFO controller for an external dual-port synchronous-read
// block RAM (port 1 write-only, port 2 read-only). A two-entry output buffer
// hides the one-cycle read latency so both sides can move one word per clock.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_data     ingress stream; s_ready = !full
//   s_afull                    registered almost-full (BRAM count >= AFULL_THRESH)
//   m_valid/m_ready/m_data     egress stream, head of the output buffer
//   level                      words held: BRAM + in-flight read + output buffer
//   bram_addr1/wdata1/we1      BRAM write port (write pointer, data, enable)
//   bram_addr2/rdata2/we2      BRAM read port (read pointer, data next clk, we=0)
// -----------------------------------------------------------------------------
module bram_stream_fifo
    import bram_stream_fifo_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int LOG_DEPTH    = LOG_DEPTH_DEF,
    parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    output logic                 s_afull,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [LOG_DEPTH+1:0] level,
    output logic [LOG_DEPTH-1:0] bram_addr1,
    output logic [WIDTH-1:0]     bram_wdata1,
    output logic                 bram_we1,
    output logic [LOG_DEPTH-1:0] bram_addr2,
    input  logic [WIDTH-1:0]     bram_rdata2,
    output logic                 bram_we2
);

    localparam int CNT_W = LOG_DEPTH + 1;
    localparam int LVL_W = LOG_DEPTH + 2;

    logic [LOG_DEPTH-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]      bram_count_r, bram_count_next_s;
    logic                  rd_inflight_r;
    logic                  s_afull_r;
    logic                  full_s, wr_s, pop_s, rd_en_s;
    logic                  m_valid_s;
    logic [WIDTH-1:0]      m_data_s;
    logic [OBUF_CNT_W-1:0] obuf_cnt_s;

    // Handshake and read-issue decisions, all from registered state.
    always_comb begin
        full_s  = (bram_count_r == CNT_W'(DEPTH));
        wr_s    = s_valid & ~full_s;
        pop_s   = m_valid_s & m_ready;
        // Issue is allowed even at full; the write side is what is blocked.
        rd_en_s = (bram_count_r != {CNT_W{1'b0}}) &
                  (obuf_demand(obuf_cnt_s, rd_inflight_r, pop_s) < 3'(OBUF_DEPTH));
    end

    // BRAM occupancy update; a write and an issue in the same cycle cancel.
    always_comb begin
        bram_count_next_s = bram_count_r;
        case ({wr_s, rd_en_s})
            2'b10:   bram_count_next_s = bram_count_r + CNT_W'(1);
            2'b01:   bram_count_next_s = bram_count_r - CNT_W'(1);
            default: bram_count_next_s = bram_count_r;
        endcase
    end

    // Pointers, occupancy, in-flight read flag and almost-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            bram_count_r  <= '0;
            rd_inflight_r <= 1'b0;
            s_afull_r     <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + LOG_DEPTH'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + LOG_DEPTH'(1);
            end
            bram_count_r  <= bram_count_next_s;
            rd_inflight_r <= rd_en_s;
            s_afull_r     <= (bram_count_next_s >= CNT_W'(AFULL_THRESH));
        end
    end

    // The word read last cycle lands in the output buffer on this edge.
    bram_fifo_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_inflight_r),
        .push_data (bram_rdata2),
        .pop       (pop_s),
        .head_data (m_data_s),
        .valid     (m_valid_s),
        .cnt       (obuf_cnt_s)
    );

    assign s_ready     = ~full_s;
    assign s_afull     = s_afull_r;
    assign m_valid     = m_valid_s;
    assign m_data      = m_data_s;
    assign level       = LVL_W'(bram_count_r) + LVL_W'(rd_inflight_r) + LVL_W'(obuf_cnt_s);
    assign bram_addr1  = wr_ptr_r;
    assign bram_wdata1 = s_data;
    assign bram_we1    = wr_s;
    assign bram_addr2  = rd_ptr_r;
    assign bram_we2    = 1'b0;

endmodule : bram_stream_fifo

// File: tb/tb_bram_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_fifo
// Drives bram_stream_fifo against a 512x72 synchronous-read BRAM model.
// A negedge monitor keeps a scoreboard of accepted words, compares every
// popped word and checks level / bram_we2 each cycle; the scenario tasks add
// their own targeted comparisons.
// -----------------------------------------------------------------------------
module tb_bram_stream_fifo;

    localparam int W  = 72;
    localparam int D  = 512;
    localparam int LD = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid, s_ready, s_afull;
    logic [W-1:0]  s_data;
    logic          m_valid, m_ready;
    logic [W-1:0]  m_data;
    logic [LD+1:0] level;
    logic [LD-1:0] bram_addr1, bram_addr2;
    logic [W-1:0]  bram_wdata1, bram_rdata2;
    logic          bram_we1, bram_we2;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    logic [W-1:0] q[$];

    bram_stream_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_afull    (s_afull),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level),
        .bram_addr1 (bram_addr1),
        .bram_wdata1(bram_wdata1),
        .bram_we1   (bram_we1),
        .bram_addr2 (bram_addr2),
        .bram_rdata2(bram_rdata2),
        .bram_we2   (bram_we2)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM model.
    logic [W-1:0] mem [0:D-1];
    always @(posedge clk) begin
        if (bram_we1) mem[bram_addr1] <= bram_wdata1;
        bram_rdata2 <= mem[bram_addr2];
    end

    // Scoreboard monitor: level, bram_we2, and popped data in order.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            total++;
            if (level !== 11'(q.size())) begin
                bad++;
                $display("FAIL mon_level: got %0d want %0d at %0t", level, q.size(), $time);
            end
            total++;
            if (bram_we2 !== 1'b0) begin
                bad++;
                $display("FAIL mon_we2: got %b want 0 at %0t", bram_we2, $time);
            end
            if (m_valid && m_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL mon_pop_empty: got %h want no word at %0t", m_data, $time);
                end else begin
                    logic [W-1:0] exp;
                    exp = q.pop_front();
                    if (m_data !== exp) begin
                        bad++;
                        $display("FAIL mon_data: got %h want %h at %0t", m_data, exp, $time);
                    end
                end
            end
            if (s_valid && s_ready) q.push_back(s_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 800 && q.size() != 0; i++) tick();
        tick();
        total++;
        if (q.size() != 0 || level !== 11'd0) begin
            bad++;
            $display("FAIL drain: got queue=%0d level=%0d want 0/0", q.size(), level);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (m_valid !== 1'b0)  begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        total++; if (level !== 11'd0)   begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
        total++; if (s_afull !== 1'b0)  begin bad++; $display("FAIL rst_afull: got %b want 0", s_afull); end
        total++; if (s_ready !== 1'b1)  begin bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        total++; if (bram_we1 !== 1'b0) begin bad++; $display("FAIL rst_we1: got %b want 0", bram_we1); end
        total++; if (bram_we2 !== 1'b0) begin bad++; $display("FAIL rst_we2: got %b want 0", bram_we2); end
        rst_n = 1'b1;
        q.delete();
        mon_en = 1'b1;
        tick();
        // First write in iteration 0; m_valid must appear exactly two edges later.
        for (int k = 0; k < 7; k++) begin
            s_valid = (k < 5);
            s_data  = W'(k + 1);
            m_ready = 1'b1;
            @(negedge clk);
            total++;
            if (m_valid !== (k >= 3)) begin
                bad++;
                $display("FAIL first_latency: cycle %0d got m_valid=%b want %b", k, m_valid, (k >= 3));
            end
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_fill();
        int acc = 0;
        bit stop = 1'b0;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int c = 0; c < 600 && !stop; c++) begin
            s_data = W'(32'h1000 + c);
            @(negedge clk);
            if (acc == 481) begin
                total++;
                if (s_afull !== 1'b0) begin bad++; $display("FAIL afull_479: got %b want 0", s_afull); end
            end
            if (acc == 482) begin
                total++;
                if (s_afull !== 1'b1) begin bad++; $display("FAIL afull_480: got %b want 1", s_afull); end
            end
            if (s_ready) acc++;
            else stop = 1'b1;
            @(posedge clk);
            #1;
        end
        total++;
        if (acc != 514 || level !== 11'd514) begin
            bad++;
            $display("FAIL fill_count: got acc=%0d level=%0d want 514/514", acc, level);
        end
        s_data = W'(32'hDEAD);
        @(negedge clk);
        total++;
        if (s_ready !== 1'b0 || level !== 11'd514) begin
            bad++;
            $display("FAIL fill_515th: got s_ready=%b level=%0d want 0/514", s_ready, level);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL sim_pop: got s_ready=%b m_valid=%b want 0/1", s_ready, m_valid);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = W'(32'h5151);
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1 || level !== 11'd513) begin
            bad++;
            $display("FAIL sim_ready_rise: got s_ready=%b level=%0d want 1/513", s_ready, level);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b0 || level !== 11'd514) begin
            bad++;
            $display("FAIL sim_refull: got s_ready=%b level=%0d want 0/514", s_ready, level);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_streaming();
        int bubbles = 0;
        int lvl_err = 0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            s_data = {8'hA5, 32'(i), 32'(~i)};
            @(negedge clk);
            if (i >= 4) begin
                if (!m_valid || !s_ready) bubbles++;
                if (level !== 11'd3) lvl_err++;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (bubbles != 0) begin bad++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
        total++;
        if (lvl_err != 0) begin bad++; $display("FAIL stream_level: got %0d deviations want 0", lvl_err); end
        drain();
    endtask

    task automatic test_random();
        int acc = 0;
        for (int c = 0; c < 40000 && acc < 10000; c++) begin
            s_valid = ($urandom_range(9) < 7);
            m_ready = ($urandom_range(9) < 7);
            s_data  = W'({$urandom, $urandom, $urandom});
            @(negedge clk);
            if (s_valid && s_ready) acc++;
            @(posedge clk);
            #1;
        end
        total++;
        if (acc < 10000) begin bad++; $display("FAIL random_timeout: got %0d words want 10000", acc); end
        drain();
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        bit seen = 1'b0;
        logic [W-1:0] fresh;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int c = 0; c < 400 && acc < 300; c++) begin
            s_data = W'(32'h7000 + c);
            @(negedge clk);
            if (s_ready) acc++;
            @(posedge clk);
            #1;
        end
        // One pop, one issue and one write: level stays 300 with a read in flight.
        m_ready = 1'b1;
        s_data  = W'(32'h7FFF);
        tick();
        m_ready = 1'b0;
        s_valid = 1'b0;
        #2;
        total++;
        if (level !== 11'd300) begin bad++; $display("FAIL mid_pre_level: got %0d want 300", level); end
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || level !== 11'd0) begin
            bad++;
            $display("FAIL mid_async: got m_valid=%b level=%0d want 0/0", m_valid, level);
        end
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        fresh  = 72'hC3_0123_4567_89AB_CDEF;
        s_valid = 1'b1;
        s_data  = fresh;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1'b1;
                total++;
                if (m_data !== fresh) begin
                    bad++;
                    $display("FAIL mid_first_word: got %h want %h", m_data, fresh);
                end
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL mid_timeout: got no m_valid want word %h", fresh); end
        drain();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_simultaneous();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got time %0t want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bram_stream_fifo
